adder_rr_sched_ody: RTL and testbench

- Round-robin scheduler that shares one signed add/subtract datapath of the project's full-adder type among R requesters.
- Each requester presents signed operands with a request. The block grants one at a time, registers the operands, computes the (N+2)-bit signed result and the overflow flag, then holds the tagged response until the consumer accepts it.
- Sits between the per-channel operand sources and a single result consumer.

---
 rtl/adder_rr_sched_ody.sv | 132 +++++++++++++
 tb/tb_adder_rr_sched_ody.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_sched_ody.sv
// rtl/adder_rr_sched_ody.sv - round-robin scheduler sharing one signed add/subtract datapath
module adder_rr_sched_ody #(
    parameter int N   = 3,
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [R-1:0]         req,
    input  logic [R-1:0]         sub,
    input  logic [R*(N+1)-1:0]   x_bus,
    input  logic [R*(N+1)-1:0]   y_bus,
    input  logic [R-1:0]         cin_bus,
    output logic [R-1:0]         ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [N+1:0]         rsp_sum,
    output logic                 rsp_ovf,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       id_r;
    logic [N:0]           x_r;
    logic [N:0]           y_r;
    logic                 cin_r;
    logic                 sub_r;

    logic                 found;
    logic [IDW-1:0]       win;
    logic [IDW-1:0]       ptr_nxt;
    logic [R*(N+1)-1:0]   x_sh;
    logic [R*(N+1)-1:0]   y_sh;
    logic [R-1:0]         cin_sh;
    logic [R-1:0]         sub_sh;
    logic [R-1:0]         req_sh;

    logic [N+2:0]         ext_x;
    logic [N+2:0]         ext_y;
    logic [N+2:0]         ext_c;
    logic [N+2:0]         wide;
    logic                 ovf;

    // First requesting index at or above the pointer, wrapping past R-1.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        req_sh = '0;
        for (int i = 0; i < R; i++) begin
            req_sh = req >> ((int'(ptr) + i) % R);
            if (!found && req_sh[0]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + i) % R);
            end
        end
    end

    // Route the winner's operands down to bit 0 and compute the post-grant pointer.
    always_comb begin
        x_sh    = x_bus >> (int'(win) * (N + 1));
        y_sh    = y_bus >> (int'(win) * (N + 1));
        cin_sh  = cin_bus >> win;
        sub_sh  = sub >> win;
        ptr_nxt = (int'(win) == R - 1) ? '0 : win + IDW'(1);
    end

    // Sign-extend one bit beyond the result width so the overflow test sees the true value.
    always_comb begin
        ext_x = {{2{x_r[N]}}, x_r};
        ext_y = {{2{y_r[N]}}, y_r};
        ext_c = {{(N + 2){1'b0}}, cin_r};
        wide  = sub_r ? (ext_x - ext_y + ext_c) : (ext_x + ext_y + ext_c);
        ovf   = (wide[N+2:N] != {3{wide[N]}});
    end

    assign busy = (state != S_IDLE);

    // Grant / execute / hold-response sequencer; ack is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id_r      <= '0;
            x_r       <= '0;
            y_r       <= '0;
            cin_r     <= 1'b0;
            sub_r     <= 1'b0;
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        x_r   <= x_sh[N:0];
                        y_r   <= y_sh[N:0];
                        cin_r <= cin_sh[0];
                        sub_r <= sub_sh[0];
                        id_r  <= win;
                        ack   <= R'(1) << win;
                        ptr   <= ptr_nxt;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_sum   <= wide[N+1:0];
                    rsp_ovf   <= ovf;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_sched_ody.sv
// tb/tb_adder_rr_sched_ody.sv - self-checking bench for adder_rr_sched_ody
module tb_adder_rr_sched_ody;
    localparam int N   = 3;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [R-1:0]       req;
    logic [R-1:0]       sub;
    logic [R*(N+1)-1:0] x_bus;
    logic [R*(N+1)-1:0] y_bus;
    logic [R-1:0]       cin_bus;
    logic [R-1:0]       ack;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [N+1:0]       rsp_sum;
    logic               rsp_ovf;
    logic               busy;

    logic signed [N:0]  xs [R];
    logic signed [N:0]  ys [R];

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    adder_rr_sched_ody #(.N(N), .R(R), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sub(sub), .x_bus(x_bus), .y_bus(y_bus),
        .cin_bus(cin_bus), .ack(ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        x_bus = '0;
        y_bus = '0;
        for (int i = 0; i < R; i++) begin
            x_bus[i*(N+1) +: N+1] = xs[i];
            y_bus[i*(N+1) +: N+1] = ys[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: winner is the first request at or after the model pointer.
    function automatic int pick(input logic [R-1:0] m);
        for (int i = 0; i < R; i++)
            if (m[(mptr + i) % R]) return (mptr + i) % R;
        return -1;
    endfunction

    function automatic int exp_sum(input int i);
        return int'(xs[i]) + (sub[i] ? -int'(ys[i]) : int'(ys[i])) + int'(cin_bus[i]);
    endfunction

    function automatic logic exp_ovf(input int s);
        return (s < -(2 ** N)) || (s > (2 ** N) - 1);
    endfunction

    task automatic rand_opnd(input int i);
        do begin
            xs[i]      = (N+1)'($urandom_range(0, 15));
            ys[i]      = (N+1)'($urandom_range(0, 15));
            sub[i]     = 1'($urandom_range(0, 1));
            cin_bus[i] = 1'($urandom_range(0, 1));
        end while (xs[i] == 7 && ys[i] == -8 && sub[i] && cin_bus[i]);
    endtask

    task automatic reset_dut;
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    // Drives one transaction and reports what was observed; callers judge it.
    task automatic issue_op(input int stall, input bit drop,
                            output logic [R-1:0] a_obs, output int wcyc,
                            output logic [R-1:0] a_next, output logic v_obs,
                            output int id_obs, output int sum_obs, output logic ovf_obs);
        wcyc  = 0;
        a_obs = '0;
        while (wcyc < 20) begin
            tick;
            wcyc++;
            if (ack != '0) break;
        end
        a_obs = ack;
        if (ack == '0) wcyc = -1;
        if (drop) req = '0;
        rsp_ready = (stall == 0);
        tick;
        a_next  = ack;
        v_obs   = rsp_valid;
        id_obs  = int'(rsp_id);
        sum_obs = int'($signed(rsp_sum));
        ovf_obs = rsp_ovf;
        repeat (stall) tick;
        rsp_ready = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        for (int i = 0; i < R; i++) begin
            xs[i] = '0; ys[i] = '0;
        end
        sub = '0; cin_bus = '0;
        reset_dut;
        checks++; if ({ack, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy} !== '0) begin failures++;
            $display("FAIL reset_outputs got=%h exp=0", {ack, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy}); end
    endtask

    task automatic test_add_basic;
        logic [R-1:0] a, an; logic v, o; int w, id, s;
        xs[0] = 7; ys[0] = 7; cin_bus[0] = 1'b1; sub[0] = 1'b0;
        req = 4'b0001;
        mptr = 1;
        issue_op(0, 1'b1, a, w, an, v, id, s, o);
        checks++; if (a !== 4'b0001) begin failures++; $display("FAIL add_ack got=%b exp=0001", a); end
        checks++; if (w !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", w); end
        checks++; if (an !== 4'b0000) begin failures++; $display("FAIL add_ack_pulse got=%b exp=0000", an); end
        checks++; if (v !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", v); end
        checks++; if (s !== 15 || o !== 1'b1 || id !== 0) begin failures++;
            $display("FAIL add_result got sum=%0d ovf=%b id=%0d exp sum=15 ovf=1 id=0", s, o, id); end
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++;
            $display("FAIL add_idle got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
    endtask

    task automatic test_sub_boundary;
        logic [R-1:0] a, an; logic v, o; int w, id, s;
        xs[1] = -8; ys[1] = 7; cin_bus[1] = 1'b0; sub[1] = 1'b1;
        req = 4'b0010;
        mptr = 2;
        issue_op(0, 1'b1, a, w, an, v, id, s, o);
        checks++; if (a !== 4'b0010 || s !== -15 || o !== 1'b1 || id !== 1) begin failures++;
            $display("FAIL sub_neg got ack=%b sum=%0d ovf=%b id=%0d exp ack=0010 sum=-15 ovf=1 id=1", a, s, o, id); end
        xs[1] = -3; ys[1] = 4; cin_bus[1] = 1'b1; sub[1] = 1'b0;
        req = 4'b0010;
        issue_op(0, 1'b1, a, w, an, v, id, s, o);
        checks++; if (a !== 4'b0010 || s !== 2 || o !== 1'b0) begin failures++;
            $display("FAIL add_small got ack=%b sum=%0d ovf=%b exp ack=0010 sum=2 ovf=0", a, s, o); end
    endtask

    task automatic test_fairness;
        logic [R-1:0] a, an, ea; logic v, o; int w, id, s, win, es;
        reset_dut;
        for (int i = 0; i < R; i++) rand_opnd(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            win  = pick(req);
            mptr = (win + 1) % R;
            es   = exp_sum(win);
            ea   = 4'(1) << win;
            issue_op(0, 1'b0, a, w, an, v, id, s, o);
            checks++; if (a !== ea || w !== 1 || id !== win) begin failures++;
                $display("FAIL fair_grant%0d got ack=%b wait=%0d id=%0d exp ack=%b wait=1 id=%0d", k, a, w, id, ea, win); end
            checks++; if (v !== 1'b1 || s !== es || o !== exp_ovf(es)) begin failures++;
                $display("FAIL fair_result%0d got v=%b sum=%0d ovf=%b exp v=1 sum=%0d ovf=%b", k, v, s, o, es, exp_ovf(es)); end
            rand_opnd(win);
        end
        req = '0;
        checks++; if (mptr !== 1) begin failures++; $display("FAIL fair_order_end got=%0d exp=1", mptr); end
    endtask

    task automatic test_backpressure;
        int win, es, es2, win2, cyc;
        logic [R-1:0] ea;
        for (int i = 0; i < R; i++) rand_opnd(i);
        req = 4'b0110;
        win = pick(req); mptr = (win + 1) % R; es = exp_sum(win);
        cyc = 0;
        while (cyc < 20) begin tick; cyc++; if (ack != '0) break; end
        ea = 4'(1) << win;
        checks++; if (ack !== ea) begin failures++; $display("FAIL bp_first_ack got=%b exp=%b", ack, ea); end
        rsp_ready = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++; if (rsp_valid !== 1'b1 || int'($signed(rsp_sum)) !== es || int'(rsp_id) !== win || ack !== '0) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b sum=%0d id=%0d ack=%b exp v=1 sum=%0d id=%0d ack=0", k, rsp_valid,
                         $signed(rsp_sum), rsp_id, ack, es, win); end
        end
        rsp_ready = 1'b1;
        tick;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
        win2 = pick(req); mptr = (win2 + 1) % R; es2 = exp_sum(win2);
        tick;
        ea = 4'(1) << win2;
        checks++; if (ack !== ea || win2 !== 2) begin failures++; $display("FAIL bp_next_grant got=%b exp=%b", ack, ea); end
        req = '0;
        tick;
        checks++; if (int'($signed(rsp_sum)) !== es2 || int'(rsp_id) !== win2) begin failures++;
            $display("FAIL bp_next_result got sum=%0d id=%0d exp sum=%0d id=%0d", $signed(rsp_sum), rsp_id, es2, win2); end
        tick;
    endtask

    task automatic test_midop_reset;
        int cyc, es;
        rand_opnd(0);
        req = 4'b0001;
        cyc = 0;
        while (cyc < 20) begin tick; cyc++; if (ack != '0) break; end
        req = '0;
        checks++; if (ack !== 4'b0001 || busy !== 1'b1) begin failures++;
            $display("FAIL mid_pre_ack got ack=%b busy=%b exp 0001 1", ack, busy); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({ack, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy} !== '0) begin failures++;
            $display("FAIL mid_async_clear got=%h exp=0", {ack, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy}); end
        rand_opnd(3);
        req = 4'b1000;
        #2;
        rst_n = 1'b1;
        mptr = 0;
        mptr = (pick(req) + 1) % R;
        es = exp_sum(3);
        tick;
        checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL mid_first_ack got=%b exp=1000", ack); end
        req = '0;
        tick;
        checks++; if (rsp_valid !== 1'b1 || int'($signed(rsp_sum)) !== es || rsp_ovf !== exp_ovf(es)) begin failures++;
            $display("FAIL mid_result got v=%b sum=%0d ovf=%b exp v=1 sum=%0d ovf=%b", rsp_valid, $signed(rsp_sum),
                     rsp_ovf, es, exp_ovf(es)); end
        tick;
    endtask

    task automatic test_pointer_wrap;
        logic [R-1:0] a, an, ea; logic v, o; int w, id, s, win, es;
        for (int i = 0; i < R; i++) rand_opnd(i);
        req = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            win = pick(req); mptr = (win + 1) % R; es = exp_sum(win);
            ea  = 4'(1) << win;
            issue_op(0, 1'b0, a, w, an, v, id, s, o);
            checks++; if (a !== ea || (k == 0 && win !== 0) || (k == 1 && win !== 2) || s !== es) begin failures++;
                $display("FAIL wrap%0d got ack=%b sum=%0d exp ack=%b sum=%0d", k, a, s, ea, es); end
        end
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            win = pick(req); mptr = (win + 1) % R; es = exp_sum(win);
            issue_op(0, 1'b0, a, w, an, v, id, s, o);
            checks++; if (a !== 4'b0100 || w !== 1 || s !== es || o !== exp_ovf(es)) begin failures++;
                $display("FAIL lone%0d got ack=%b wait=%0d sum=%0d exp ack=0100 wait=1 sum=%0d", k, a, w, s, es); end
            rand_opnd(2);
        end
        req = '0;
    endtask

    task automatic test_random;
        logic [R-1:0] a, an, ea, m; logic v, o; int w, id, s, win, es, st;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < R; i++) rand_opnd(i);
            m   = 4'($urandom_range(1, 15));
            st  = $urandom_range(0, 3);
            req = m;
            win = pick(m); mptr = (win + 1) % R; es = exp_sum(win);
            ea  = 4'(1) << win;
            issue_op(st, 1'b1, a, w, an, v, id, s, o);
            checks++; if (a !== ea || an !== '0 || id !== win || v !== 1'b1 || s !== es || o !== exp_ovf(es)) begin
                failures++;
                $display("FAIL rand%0d got ack=%b id=%0d v=%b sum=%0d ovf=%b exp ack=%b id=%0d v=1 sum=%0d ovf=%b",
                         k, a, id, v, s, o, ea, win, es, exp_ovf(es)); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        test_reset;
        test_add_basic;
        test_sub_boundary;
        test_fairness;
        test_backpressure;
        test_midop_reset;
        test_pointer_wrap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
